ft245_fifo_responder: RTL

- Device-side model of the FT245-style USB parallel FIFO that the board glue logic drives through `_rd`, `wr`, `_rdf`, `_txe` and an 8-bit data bus.
- Buffers bytes arriving from the PC side (RX) and presents them to bus read strobes. Captures bus write strobes into a TX buffer drained by the PC side.
- Serves as the synthesizable stand-in for the USB chip in FPGA bring-up and as the bus-accurate responder in system benches.

---
 rtl/ft245_pkg.sv | 24 ++
 rtl/ft245_fifo_responder_if.sv | 34 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/ft245_fifo_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245-style FIFO responder.
package ft245_pkg;

    localparam int unsigned DATA_W = 8;

    // Bus strobe levels when no transfer is in progress.
    localparam logic RD_IDLE = 1'b1;
    localparam logic WR_IDLE = 1'b0;

    // Byte presented on a bus read that finds RX empty.
    localparam logic [DATA_W-1:0] UDF_FILL = 8'hFF;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACTIVE,
        R_RECOVER
    } rd_state_t;

    typedef enum logic {
        W_IDLE,
        W_RECOVER
    } wr_state_t;

endpackage

// File: rtl/ft245_fifo_responder_if.sv
// Bus-side and PC-side signals of the FT245 responder.
interface ft245_fifo_responder_if;
    import ft245_pkg::*;

    // CPU bus side
    logic              _rd;
    logic              wr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              d_oe;
    logic              _rdf;
    logic              _txe;

    // PC side
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // The responder (USB chip stand-in)
    modport slave (
        input  _rd, wr, d_in, in_data, in_valid, out_ready,
        output d_out, d_oe, _rdf, _txe, in_ready, out_data, out_valid
    );

    // The bus host and PC-side driver
    modport master (
        output _rd, wr, d_in, in_data, in_valid, out_ready,
        input  d_out, d_oe, _rdf, _txe, in_ready, out_data, out_valid
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extended-pointer full/empty; head shown from storage.
module sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wp;
    logic [AW:0]       rp;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Full/empty come from registered pointers, so a push into a full FIFO
    // is refused even when a pop happens in the same cycle.
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rp[AW-1:0]];

    // Pointer update; pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ft245_fifo_responder.sv
// Device-side FT245 parallel FIFO model: RX buffer read by bus strobes,
// TX buffer filled by bus writes, PC side as valid/ready streams.
module ft245_fifo_responder
    import ft245_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   _reset,
    ft245_fifo_responder_if.slave  bus,
    output logic                   ovf,
    output logic                   udf
);

    // Synchronizers and edge detection
    logic [SYNC_STAGES-1:0] rd_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic [DATA_W-1:0]      d_sync [SYNC_STAGES];
    logic                   rd_s, wr_s, rd_p, wr_p;
    logic [DATA_W-1:0]      d_s;
    logic                   rd_fall, rd_rise, wr_fall;

    // FIFO connections
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_head, tx_din;

    // Read side state
    rd_state_t         rstate, rstate_n;
    logic              pop_pend, pop_pend_n;
    logic [DATA_W-1:0] d_out_q, d_out_n;
    logic              d_oe_q;
    logic              udf_q, udf_n;

    // Write side state
    wr_state_t         wstate, wstate_n;
    logic              wr_pend, wr_pend_n;
    logic [DATA_W-1:0] wr_pend_data, wr_pend_data_n;
    logic              ovf_q, ovf_n;

    // Low during reset, high from the first clock after release.
    logic              running;

    assign rd_s    = rd_sync[SYNC_STAGES-1];
    assign wr_s    = wr_sync[SYNC_STAGES-1];
    assign d_s     = d_sync[SYNC_STAGES-1];
    assign rd_fall = rd_p & ~rd_s;
    assign rd_rise = ~rd_p & rd_s;
    assign wr_fall = wr_p & ~wr_s;

    // Strobe and data synchronizer chains plus one edge-detect stage.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            rd_sync <= {SYNC_STAGES{RD_IDLE}};
            wr_sync <= {SYNC_STAGES{WR_IDLE}};
            for (int unsigned i = 0; i < SYNC_STAGES; i++) d_sync[i] <= '0;
            rd_p    <= RD_IDLE;
            wr_p    <= WR_IDLE;
        end else begin
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], bus._rd};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.wr};
            d_sync[0] <= bus.d_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) d_sync[i] <= d_sync[i-1];
            rd_p    <= rd_s;
            wr_p    <= wr_s;
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx (
        .clk    (clk),
        ._reset (_reset),
        .push   (rx_push),
        .din    (bus.in_data),
        .pop    (rx_pop),
        .head   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx (
        .clk    (clk),
        ._reset (_reset),
        .push   (tx_push),
        .din    (tx_din),
        .pop    (tx_pop),
        .head   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    assign rx_push = bus.in_valid & bus.in_ready;
    assign tx_pop  = bus.out_valid & bus.out_ready;

    // State registers for both strobe machines and the bus outputs.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            running      <= 1'b0;
            rstate       <= R_IDLE;
            pop_pend     <= 1'b0;
            d_out_q      <= '0;
            d_oe_q       <= 1'b0;
            udf_q        <= 1'b0;
            wstate       <= W_IDLE;
            wr_pend      <= 1'b0;
            wr_pend_data <= '0;
            ovf_q        <= 1'b0;
        end else begin
            running      <= 1'b1;
            rstate       <= rstate_n;
            pop_pend     <= pop_pend_n;
            d_out_q      <= d_out_n;
            d_oe_q       <= (rstate == R_ACTIVE);
            udf_q        <= udf_n;
            wstate       <= wstate_n;
            wr_pend      <= wr_pend_n;
            wr_pend_data <= wr_pend_data_n;
            ovf_q        <= ovf_n;
        end
    end

    // Read machine: latch head on strobe start, pop only once the strobe ends.
    always_comb begin
        rstate_n   = rstate;
        pop_pend_n = pop_pend;
        d_out_n    = d_out_q;
        udf_n      = udf_q;
        rx_pop     = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (rd_fall) begin
                    rstate_n = R_ACTIVE;
                    if (rx_empty) begin
                        d_out_n    = UDF_FILL;
                        udf_n      = 1'b1;
                        pop_pend_n = 1'b0;
                    end else begin
                        d_out_n    = rx_head;
                        pop_pend_n = 1'b1;
                    end
                end
            end
            R_ACTIVE: begin
                if (rd_rise) begin
                    rx_pop     = pop_pend;
                    pop_pend_n = 1'b0;
                    rstate_n   = R_RECOVER;
                end
            end
            R_RECOVER: rstate_n = R_IDLE;
            default:   rstate_n = R_IDLE;
        endcase
    end

    // Write machine: a falling edge seen during recovery is held in a
    // one-deep queue (with its byte) and serviced on return to idle.
    always_comb begin
        wstate_n       = wstate;
        wr_pend_n      = wr_pend;
        wr_pend_data_n = wr_pend_data;
        ovf_n          = ovf_q;
        tx_push        = 1'b0;
        tx_din         = d_s;
        case (wstate)
            W_IDLE: begin
                if (wr_pend || wr_fall) begin
                    wstate_n       = W_RECOVER;
                    tx_din         = wr_pend ? wr_pend_data : d_s;
                    if (tx_full) ovf_n   = 1'b1;
                    else         tx_push = 1'b1;
                    wr_pend_n      = wr_pend & wr_fall;
                    wr_pend_data_n = d_s;
                end
            end
            W_RECOVER: begin
                wstate_n = W_IDLE;
                if (wr_fall) begin
                    wr_pend_n      = 1'b1;
                    wr_pend_data_n = d_s;
                end
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    assign bus.d_out     = d_out_q;
    assign bus.d_oe      = d_oe_q;
    assign bus._rdf      = ~running | rx_empty | (rstate != R_IDLE);
    assign bus._txe      = ~running | tx_full | (wstate == W_RECOVER);
    assign bus.in_ready  = running & ~rx_full;
    assign bus.out_valid = ~tx_empty;
    assign bus.out_data  = tx_head;
    assign ovf           = ovf_q;
    assign udf           = udf_q;

endmodule
